gray_ptr_sync: RTL and testbench

Parametrised multi-stage synchroniser for Gray-coded FIFO pointers crossing into the local clock domain. It is the next generation of the fixed 4-bit, 2-stage pointer synchroniser in the async FIFO. It adds:
- configurable width and stage count;
- Gray-to-binary conversion;
- a change strobe;
- Gray-code integrity checking, which flags any synchronised update that differs from the previous value by more than one bit.

It sits on both the write-to-read and read-to-write pointer paths of the async FIFO.

---
 rtl/gray_ptr_sync_if.sv | 25 ++
 rtl/gray_ptr_sync.sv | 70 +++++++
 tb/tb_gray_ptr_sync.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_sync_if.sv
// Bundle of the Gray pointer synchroniser signals. The master side drives the foreign-domain
// pointer and the error clear; the slave side returns the synchronised views and status.
interface gray_ptr_sync_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     async_gray;
    logic                 err_clr;
    logic [WIDTH-1:0]     sync_gray;
    logic [WIDTH-1:0]     sync_bin;
    logic                 ptr_changed;
    logic                 hop_err;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output async_gray, err_clr,
        input  sync_gray, sync_bin, ptr_changed, hop_err, err_sticky, err_cnt
    );

    modport slave (
        input  async_gray, err_clr,
        output sync_gray, sync_bin, ptr_changed, hop_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer with Gray-to-binary conversion,
// change strobe and a checker that flags any synchronised update of more than one bit.
module gray_ptr_sync #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STAGES    = 2,
    parameter bit          CHECK_EN  = 1'b1,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic            clk,
    input logic            nrst,
    gray_ptr_sync_if.slave bus
);
    localparam logic [ERR_CNT_W-1:0] CntMax = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]     sync_q [STAGES];
    logic [WIDTH-1:0]     hold_q;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     bin;
    logic                 changed_q;
    logic                 hop_q;
    logic                 hop_d;
    logic                 sticky_q;
    logic                 sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [ERR_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            hold_q    <= '0;
            changed_q <= 1'b0;
            hop_q     <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q[0] <= bus.async_gray;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            hold_q    <= sync_q[STAGES-1];
            changed_q <= |diff;
            hop_q     <= hop_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign diff  = sync_q[STAGES-1] ^ hold_q;
    assign hop_d = CHECK_EN && ($countones(diff) > 1);

    // Clear first, then record a coincident error, so a simultaneous clear never loses it.
    always_comb begin
        sticky_d = bus.err_clr ? 1'b0 : sticky_q;
        cnt_d    = bus.err_clr ? '0 : cnt_q;
        if (hop_d) begin
            sticky_d = 1'b1;
            if (cnt_d != CntMax) cnt_d = cnt_d + 1'b1;
        end
    end

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) bin[i] = ^(sync_q[STAGES-1] >> i);
    end

    assign bus.sync_gray   = sync_q[STAGES-1];
    assign bus.sync_bin    = bin;
    assign bus.ptr_changed = changed_q;
    assign bus.hop_err     = hop_q;
    assign bus.err_sticky  = sticky_q;
    assign bus.err_cnt     = cnt_q;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: directed scenarios plus random traffic against a history-based model.
module tb_gray_ptr_sync;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CW     = 2;
    localparam int          CMAX   = (1 << CW) - 1;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    gray_ptr_sync_if #(.WIDTH(4), .ERR_CNT_W(CW)) bus ();

    gray_ptr_sync #(
        .WIDTH    (4),
        .STAGES   (STAGES),
        .CHECK_EN (1'b1),
        .ERR_CNT_W(CW)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: input history (delay line) and history of synchronised values, newest first.
    logic [3:0] in_hist[$];
    logic [3:0] sync_hist[$];
    logic       m_chg;
    logic       m_hop;
    logic       m_sticky;
    int         m_cnt;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] v;
        v = 4'(n);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        for (int n = 0; n < 16; n++) if (to_gray(n) == g) return 4'(n);
        return 4'hx;
    endfunction

    task automatic reset_model();
        in_hist   = {};
        sync_hist = {};
        repeat (STAGES) in_hist.push_front(4'b0);
        repeat (3) sync_hist.push_front(4'b0);
        m_chg    = 1'b0;
        m_hop    = 1'b0;
        m_sticky = 1'b0;
        m_cnt    = 0;
    endtask

    // Drive one cycle of input, advance the model across the edge, return at the next negedge.
    task automatic tick(input logic [3:0] g, input logic clr);
        bus.async_gray = g;
        bus.err_clr    = clr;
        @(posedge clk);
        in_hist.push_front(g);
        void'(in_hist.pop_back());
        sync_hist.push_front(in_hist[STAGES-1]);
        void'(sync_hist.pop_back());
        m_chg = (sync_hist[1] != sync_hist[2]);
        m_hop = ($countones(sync_hist[1] ^ sync_hist[2]) > 1);
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end
        if (m_hop) begin
            m_sticky = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst           = 1'b0;
        bus.async_gray = 4'b0;
        bus.err_clr    = 1'b0;
        reset_model();
        #1;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst           = 1'b0;
        bus.async_gray = 4'b1111;
        bus.err_clr    = 1'b0;
        #1;
        checks++;
        if ({bus.sync_gray, bus.sync_bin, bus.ptr_changed, bus.hop_err, bus.err_sticky,
             bus.err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gray=%b bin=%b chg=%b hop=%b st=%b cnt=%0d want all 0",
                     bus.sync_gray, bus.sync_bin, bus.ptr_changed, bus.hop_err,
                     bus.err_sticky, bus.err_cnt);
        end
        do_reset();
    endtask

    task automatic test_first_jump();
        do_reset();
        tick(4'b0011, 1'b0);
        checks++;
        if (bus.sync_gray !== 4'b0000) begin
            errors++;
            $display("FAIL jump_latency_early: got %b want 0000", bus.sync_gray);
        end
        tick(4'b0011, 1'b0);
        checks++;
        if (bus.sync_gray !== 4'b0011 || bus.sync_bin !== 4'd2) begin
            errors++;
            $display("FAIL jump_sync: got gray=%b bin=%0d want gray=0011 bin=2",
                     bus.sync_gray, bus.sync_bin);
        end
        tick(4'b0011, 1'b0);
        checks++;
        if (bus.ptr_changed !== 1'b1 || bus.hop_err !== 1'b1 || bus.err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL jump_pulse: got chg=%b hop=%b cnt=%0d want 1 1 1",
                     bus.ptr_changed, bus.hop_err, bus.err_cnt);
        end
        tick(4'b0011, 1'b0);
        checks++;
        if (bus.ptr_changed !== 1'b0 || bus.hop_err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL jump_one_shot: got chg=%b hop=%b st=%b want 0 0 1",
                     bus.ptr_changed, bus.hop_err, bus.err_sticky);
        end
    endtask

    task automatic test_gray_walk();
        int pulses;
        int hops;
        int bin_bad;
        pulses  = 0;
        hops    = 0;
        bin_bad = 0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            repeat (3) begin
                tick(to_gray(k % 16), 1'b0);
                if (bus.ptr_changed === 1'b1) pulses++;
                if (bus.hop_err !== 1'b0) hops++;
                if (bus.sync_bin !== gray2bin(sync_hist[0])) bin_bad++;
            end
        end
        checks++;
        if (pulses != 16) begin
            errors++;
            $display("FAIL walk_pulses: got %0d want 16", pulses);
        end
        checks++;
        if (hops != 0 || bus.err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL walk_hop: got hops=%0d cnt=%0d want 0 0", hops, bus.err_cnt);
        end
        checks++;
        if (bin_bad != 0 || bus.sync_bin !== 4'd0) begin
            errors++;
            $display("FAIL walk_bin: got %0d bad cycles, final bin=%0d want 0 bad, bin=0",
                     bin_bad, bus.sync_bin);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [7];
        int run;
        int best;
        int hops;
        seq  = '{4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        run  = 0;
        best = 0;
        hops = 0;
        do_reset();
        foreach (seq[i]) begin
            tick(seq[i], 1'b0);
            run = (bus.ptr_changed === 1'b1) ? run + 1 : 0;
            if (run > best) best = run;
            if (bus.hop_err !== 1'b0) hops++;
        end
        checks++;
        if (best != 3 || hops != 0) begin
            errors++;
            $display("FAIL back_to_back: got run=%0d hops=%0d want run=3 hops=0", best, hops);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] vals [5];
        vals = '{4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
        do_reset();
        foreach (vals[i]) repeat (3) tick(vals[i], 1'b0);
        checks++;
        if (bus.err_cnt !== 2'd3 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d st=%b want 3 1", bus.err_cnt, bus.err_sticky);
        end
        tick(4'b0101, 1'b1);
        checks++;
        if (bus.err_cnt !== 2'd0 || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got cnt=%0d st=%b want 0 0", bus.err_cnt, bus.err_sticky);
        end
    endtask

    task automatic test_clr_collision();
        do_reset();
        repeat (3) tick(4'b0011, 1'b0);
        tick(4'b0110, 1'b0);
        tick(4'b0110, 1'b0);
        tick(4'b0110, 1'b1);
        checks++;
        if (bus.hop_err !== 1'b1 || bus.err_sticky !== 1'b1 || bus.err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL clr_collision: got hop=%b st=%b cnt=%0d want 1 1 1",
                     bus.hop_err, bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        int pos;
        int bad;
        int r;
        pos = 0;
        bad = 0;
        g   = 4'b0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(99));
            if (r < 35) begin
                pos = (pos + 1) % 16;
                g   = to_gray(pos);
            end else if (r < 50) begin
                g   = 4'($urandom);
                pos = int'(gray2bin(g));
            end
            tick(g, ($urandom_range(9) == 0));
            checks++;
            if (bus.sync_gray !== sync_hist[0] || bus.sync_bin !== gray2bin(sync_hist[0]) ||
                bus.ptr_changed !== m_chg || bus.hop_err !== m_hop ||
                bus.err_sticky !== m_sticky || bus.err_cnt !== CW'(m_cnt)) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random[%0d]: got g=%b b=%0d c=%b h=%b s=%b n=%0d want g=%b b=%0d c=%b h=%b s=%b n=%0d",
                             n, bus.sync_gray, bus.sync_bin, bus.ptr_changed, bus.hop_err,
                             bus.err_sticky, bus.err_cnt, sync_hist[0], gray2bin(sync_hist[0]),
                             m_chg, m_hop, m_sticky, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) tick(4'b1100, 1'b0);
        checks++;
        if (bus.sync_gray !== 4'b1100 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got gray=%b st=%b want 1100 1", bus.sync_gray, bus.err_sticky);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({bus.sync_gray, bus.sync_bin, bus.ptr_changed, bus.hop_err, bus.err_sticky,
             bus.err_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got gray=%b chg=%b hop=%b st=%b cnt=%0d want all 0",
                     bus.sync_gray, bus.ptr_changed, bus.hop_err, bus.err_sticky, bus.err_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.ptr_changed !== 1'b0 || bus.hop_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_pulse: got chg=%b hop=%b want 0 0", bus.ptr_changed, bus.hop_err);
        end
        reset_model();
        nrst = 1'b1;
        tick(4'b1100, 1'b0);
        tick(4'b1100, 1'b0);
        checks++;
        if (bus.sync_gray !== 4'b1100 || bus.ptr_changed !== 1'b0) begin
            errors++;
            $display("FAIL mid_resync: got gray=%b chg=%b want 1100 0", bus.sync_gray, bus.ptr_changed);
        end
        tick(4'b1100, 1'b0);
        checks++;
        if (bus.ptr_changed !== 1'b1 || bus.hop_err !== 1'b1 || bus.err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mid_after: got chg=%b hop=%b cnt=%0d want 1 1 1",
                     bus.ptr_changed, bus.hop_err, bus.err_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_jump();
        test_gray_walk();
        test_back_to_back();
        test_saturation();
        test_clr_collision();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
